// File: rtl/ram_bus_pkg.sv
// Shared definitions for the CPU-RAM bus: access direction codes,
// responder state encoding and the CPU bus width.
package ram_bus_pkg;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  localparam int BUS_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/ram_sp_array.sv
// Single-port synchronous word array: write-enable, read-enable and a
// registered read port that holds its value until the next enabled read.
// The storage and read register have no reset.
module ram_sp_array #(
  parameter int ADDR_BITS  = 12,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  wire_clock,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // Write port and registered read port share one address.
  always_ff @(posedge wire_clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/ram_responder.sv
// Memory-side bus responder: latches a CPU request, waits WAIT_STATES
// cycles, commits the read or write into the word array, then raises
// wire_READY for exactly one cycle. Requests seen outside IDLE are dropped.
import ram_bus_pkg::*;

module ram_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 1
) (
  input  logic                  wire_clock,
  input  logic                  wire_reset,
  input  logic [BUS_W-1:0]      bus_RAM_ADDRESS,
  input  logic                  wire_RW,
  input  logic [DATA_WIDTH-1:0] bus_RAM_DATA_IN,
  input  logic                  wire_REQ,
  output logic [DATA_WIDTH-1:0] bus_RAM_DATA_OUT,
  output logic                  wire_READY
);

  localparam logic [7:0] WAIT_INIT = 8'(WAIT_STATES);

  state_t                state;
  state_t                state_nxt;
  logic [7:0]            wait_cnt;
  logic                  accept;
  logic                  commit;
  logic                  mem_we;
  logic                  mem_re;
  logic                  rd_vld;
  logic [ADDR_BITS-1:0]  addr_q;
  logic                  rw_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata;

  // Upper address bits alias onto the decoded range and are deliberately unused.
  if (ADDR_BITS < BUS_W) begin : g_alias
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus_RAM_ADDRESS[BUS_W-1:ADDR_BITS];
  end

  // State register.
  always_ff @(posedge wire_clock) begin
    if (wire_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode; a reset on the commit edge suppresses the memory access.
  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    commit     = 1'b0;
    wire_READY = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wire_REQ) begin
          accept    = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (wait_cnt == 8'd0) begin
          commit    = 1'b1;
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        wire_READY = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    mem_we = commit && (rw_q == RW_WRITE) && !wire_reset;
    mem_re = commit && (rw_q == RW_READ) && !wire_reset;
  end

  // Wait-state counter: loaded on accept, counts down to zero and stops there.
  always_ff @(posedge wire_clock) begin
    if (wire_reset) begin
      wait_cnt <= 8'd0;
    end else if (accept) begin
      wait_cnt <= WAIT_INIT;
    end else if (state == ST_BUSY && wait_cnt != 8'd0) begin
      wait_cnt <= wait_cnt - 8'd1;
    end
  end

  // Request latches: inputs are captured only on the accepting edge.
  always_ff @(posedge wire_clock) begin
    if (accept) begin
      addr_q  <= bus_RAM_ADDRESS[ADDR_BITS-1:0];
      rw_q    <= wire_RW;
      wdata_q <= bus_RAM_DATA_IN;
    end
  end

  // Read-data qualifier: the array read register has no reset, so the output
  // reads as zero until the first read commits after reset.
  always_ff @(posedge wire_clock) begin
    if (wire_reset) begin
      rd_vld <= 1'b0;
    end else if (mem_re) begin
      rd_vld <= 1'b1;
    end
  end

  ram_sp_array #(
    .ADDR_BITS  (ADDR_BITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .wire_clock (wire_clock),
    .we         (mem_we),
    .re         (mem_re),
    .addr       (addr_q),
    .wdata      (wdata_q),
    .rdata      (rdata)
  );

  assign bus_RAM_DATA_OUT = rd_vld ? rdata : '0;

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: three instances (WAIT_STATES 0, 1, 3) share the
// data/address/reset inputs and have private REQ lines. A word-level memory
// model per instance predicts read data, output hold and handshake timing.
module tb_ram_responder;

  localparam int WS [3] = '{0, 1, 3};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        rw;
  logic [15:0] wdata;
  logic        req   [3];
  logic [15:0] dout  [3];
  logic        ready [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] mem_m    [3][4096];
  bit          known    [3][4096];
  logic [15:0] dout_m   [3];
  int          last_rdy [3];

  typedef struct {
    int          d;
    logic        w;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram_responder #(.ADDR_BITS(12), .DATA_WIDTH(16), .WAIT_STATES(0)) dut0 (
    .wire_clock(clk), .wire_reset(rst), .bus_RAM_ADDRESS(addr), .wire_RW(rw),
    .bus_RAM_DATA_IN(wdata), .wire_REQ(req[0]), .bus_RAM_DATA_OUT(dout[0]),
    .wire_READY(ready[0]));

  ram_responder #(.ADDR_BITS(12), .DATA_WIDTH(16), .WAIT_STATES(1)) dut1 (
    .wire_clock(clk), .wire_reset(rst), .bus_RAM_ADDRESS(addr), .wire_RW(rw),
    .bus_RAM_DATA_IN(wdata), .wire_REQ(req[1]), .bus_RAM_DATA_OUT(dout[1]),
    .wire_READY(ready[1]));

  ram_responder #(.ADDR_BITS(12), .DATA_WIDTH(16), .WAIT_STATES(3)) dut3 (
    .wire_clock(clk), .wire_reset(rst), .bus_RAM_ADDRESS(addr), .wire_RW(rw),
    .bus_RAM_DATA_IN(wdata), .wire_REQ(req[2]), .bus_RAM_DATA_OUT(dout[2]),
    .wire_READY(ready[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) dout_m[i] = 16'h0000;
  endtask

  // One complete handshake on instance d. Returns in the cycle after READY,
  // where the next request may already be driven.
  task automatic access(input int d, input logic w, input logic [15:0] a,
                        input logic [15:0] wd, input bit drop,
                        output logic [15:0] got, output logic [15:0] expm);
    int lat;
    rw = w; addr = a; wdata = wd; req[d] = 1'b1;
    step();
    req[d] = 1'b0;
    addr  = 16'($urandom);
    wdata = 16'($urandom);
    rw    = 1'($urandom);
    if (drop) begin
      req[d] = 1'b1; rw = 1'b1; addr = 16'h0020; wdata = 16'hAAAA;
    end
    lat = 0;
    while (!ready[d] && lat < 300) begin
      step();
      req[d] = 1'b0;
      lat++;
    end
    chk($sformatf("latency_d%0d", d), lat, WS[d] + 1);
    got  = dout[d];
    expm = w ? dout_m[d] : mem_m[d][a[11:0]];
    if (w) begin
      mem_m[d][a[11:0]] = wd;
      known[d][a[11:0]] = 1'b1;
    end else begin
      dout_m[d] = expm;
    end
    last_rdy[d] = cyc;
    step();
    chk($sformatf("ready_one_cycle_d%0d", d), ready[d], 1'b0);
    chk($sformatf("dout_hold_d%0d", d), dout[d], dout_m[d]);
  endtask

  initial begin
    logic [15:0] got, expm;
    int          pulses, t1;

    vecs[0] = '{1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[1] = '{1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[2] = '{1, 1'b1, 16'hF005, 16'h1234, 16'hBEEF};
    vecs[3] = '{1, 1'b0, 16'h0005, 16'h0000, 16'h1234};
    vecs[4] = '{1, 1'b1, 16'h0020, 16'h1111, 16'h1234};
    vecs[5] = '{1, 1'b1, 16'h0031, 16'h0C0C, 16'h1234};
    vecs[6] = '{0, 1'b1, 16'h0ABC, 16'h00FF, 16'h0000};
    vecs[7] = '{0, 1'b0, 16'h3ABC, 16'h0000, 16'h00FF};
    vecs[8] = '{2, 1'b1, 16'h0030, 16'h0F0F, 16'h0000};
    vecs[9] = '{2, 1'b0, 16'h1030, 16'h0000, 16'h0F0F};

    rst = 1'b1; addr = '0; rw = 1'b0; wdata = '0;
    for (int i = 0; i < 3; i++) req[i] = 1'b0;
    model_reset();
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_ready_d%0d", i), ready[i], 1'b0);
      chk($sformatf("reset_dout_d%0d", i), dout[i], 16'h0000);
    end
    rst = 1'b0;
    step();

    // Directed vectors: write/read, aliasing, write leaves DATA_OUT alone.
    for (int i = 0; i < 10; i++) begin
      access(vecs[i].d, vecs[i].w, vecs[i].a, vecs[i].wd, 1'b0, got, expm);
      chk($sformatf("vec%0d_dout", i), got, vecs[i].exp_dout);
    end

    // A write request during BUSY is dropped: one pulse only, no write.
    access(1, 1'b0, 16'h0010, 16'h0000, 1'b1, got, expm);
    chk("drop_read_dout", got, 16'hBEEF);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (ready[1]) pulses++;
      step();
    end
    chk("drop_no_extra_ready", pulses, 0);
    access(1, 1'b0, 16'h0020, 16'h0000, 1'b0, got, expm);
    chk("drop_no_write", got, 16'h1111);

    // Reset one cycle after a write request on the WAIT_STATES=3 instance.
    rw = 1'b1; addr = 16'h0030; wdata = 16'h5555; req[2] = 1'b1;
    step();
    req[2] = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("midrst_dout", dout[2], 16'h0000);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (ready[2]) pulses++;
      step();
    end
    chk("midrst_no_ready", pulses, 0);
    access(2, 1'b0, 16'h0030, 16'h0000, 1'b0, got, expm);
    chk("midrst_old_value", got, 16'h0F0F);

    // Reset coinciding with the commit edge on the WAIT_STATES=1 instance.
    rw = 1'b1; addr = 16'h0031; wdata = 16'h7777; req[1] = 1'b1;
    step();
    req[1] = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    chk("commitrst_ready", ready[1], 1'b0);
    chk("commitrst_dout", dout[1], 16'h0000);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      if (ready[1]) pulses++;
      step();
    end
    chk("commitrst_no_ready", pulses, 0);
    access(1, 1'b0, 16'h0031, 16'h0000, 1'b0, got, expm);
    chk("commitrst_no_write", got, 16'h0C0C);

    // Back-to-back requests issued in the cycle after READY.
    access(0, 1'b0, 16'h0ABC, 16'h0000, 1'b0, got, expm);
    t1 = last_rdy[0];
    access(0, 1'b0, 16'h0ABC, 16'h0000, 1'b0, got, expm);
    chk("b2b_spacing_ws0", last_rdy[0] - t1, 3);
    access(1, 1'b0, 16'h0010, 16'h0000, 1'b0, got, expm);
    t1 = last_rdy[1];
    access(1, 1'b1, 16'h0040, 16'h4040, 1'b0, got, expm);
    chk("b2b_spacing_ws1", last_rdy[1] - t1, 4);
    access(2, 1'b0, 16'h0030, 16'h0000, 1'b0, got, expm);
    t1 = last_rdy[2];
    access(2, 1'b0, 16'h0030, 16'h0000, 1'b0, got, expm);
    chk("b2b_spacing_ws3", last_rdy[2] - t1, 6);

    // Random accesses over a small aliased pool, checked against the model.
    for (int n = 0; n < 60; n++) begin
      int          d;
      logic        w;
      logic [3:0]  hi;
      logic [11:0] lo;
      logic [15:0] a, wd;
      d  = $urandom_range(0, 2);
      hi = 4'($urandom_range(0, 15));
      lo = 12'h100 + 12'($urandom_range(0, 15));
      a  = {hi, lo};
      wd = 16'($urandom);
      w  = 1'($urandom_range(0, 1));
      if (!known[d][lo]) w = 1'b1;
      access(d, w, a, wd, 1'b0, got, expm);
      chk($sformatf("rand%0d_dout_d%0d", n, d), got, expm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
